// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one UART transmitter byte port
// between NREQ message-oriented requesters. The grant is held for a whole
// message, so bytes of different messages never interleave on TXD.
// Optional build macro: ARB_TIMEOUT_EN. When it is defined, a grant whose
// owner stays idle for TIMEOUT_CYCLES cycles is revoked and timeout_o is set.
module uart_tx_arb #(
    parameter int unsigned NREQ           = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              timeout_o
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int          NR = int'(NREQ);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [NREQ-1:0] grant_q;
    logic            tx_valid_q;
    logic [7:0]      tx_data_q;

    logic [7:0]      req_bytes [NREQ];
    logic            slot_free;
    logic            accept;
    logic            release_c;
    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   owner_next;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] idle_cnt_q;
    logic          timeout_q;
    logic          tmo_hit;
`endif

    // (base + off) mod NREQ, with base and off both below NREQ
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(32'(base)) + off;
        if (s >= NR) begin
            s = s - NR;
        end
        return IW'(s);
    endfunction

    // Unpack the per-requester byte lanes
    for (genvar i = 0; i < NR; i++) begin : g_lane
        assign req_bytes[i] = req_data[8*i +: 8];
    end

    // Round-robin pick: first valid requester starting at rr_ptr_q
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        for (int k = 0; k < NR; k++) begin
            if (!pick_found && req_valid[wrap_add(rr_ptr_q, k)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_add(rr_ptr_q, k);
            end
        end
    end

    // Handshake with the owner and release decision
    always_comb begin
        slot_free  = !tx_valid_q || tx_ready;
        accept     = (state_q == LOCKED) && req_valid[owner_q] && slot_free;
        release_c  = accept && req_last[owner_q];
        owner_next = wrap_add(owner_q, 1);
`ifdef ARB_TIMEOUT_EN
        tmo_hit    = (state_q == LOCKED) && !req_valid[owner_q] &&
                     (idle_cnt_q == CW'(TIMEOUT_CYCLES - 1));
        release_c  = release_c || tmo_hit;
`endif
    end

    // Arbitration state, grant and one-byte output register
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
`ifdef ARB_TIMEOUT_EN
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= req_bytes[owner_q];
            end else if (tx_ready) begin
                tx_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q <= LOCKED;
                        owner_q <= pick_idx;
                        grant_q <= NREQ'(1) << pick_idx;
                    end
                end
                LOCKED: begin
                    if (release_c) begin
                        state_q  <= IDLE;
                        grant_q  <= '0;
                        rr_ptr_q <= owner_next;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase

`ifdef ARB_TIMEOUT_EN
            // Count only cycles in which the owner has nothing to offer
            if (state_q != LOCKED || req_valid[owner_q]) begin
                idle_cnt_q <= '0;
            end else begin
                idle_cnt_q <= idle_cnt_q + CW'(1);
            end
            if (tmo_hit) begin
                timeout_q <= 1'b1;
            end
`endif
        end
    end

    assign req_ready = grant_q & {NREQ{slot_free}};
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign grant     = grant_q;
    assign busy      = (|grant_q) || tx_valid_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Testbench for uart_tx_arb (default build, two requesters): directed
// scenarios with literal expectations plus a randomized message stream,
// all continuously compared against a message-level reference model.
module tb_uart_tx_arb;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout_o;

    always #5 clk = ~clk;

    uart_tx_arb #(.NREQ(N), .TIMEOUT_CYCLES(4096)) dut (
        .clk       (clk),
        .rst_i     (rst_i),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .busy      (busy),
        .timeout_o (timeout_o)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (message-level view) ----------------
    int         m_own = -1;     // current owner, -1 when nobody holds the port
    bit         m_pv  = 1'b0;   // a byte is waiting for the transmitter
    logic [7:0] m_pd  = 8'h00;
    int         m_rr  = 0;      // who is searched first at the next arbitration
    logic [7:0] txd_log[$];     // bytes actually taken by the transmitter

    // Compare DUT with model mid-cycle, then advance the model over the edge
    always @(negedge clk) begin
        logic [N-1:0] eg;
        logic [N-1:0] er;
        bit           acc;
        int           c;
        eg = (m_own >= 0) ? (N'(1) << m_own) : '0;
        er = (m_own >= 0 && (!m_pv || tx_ready)) ? eg : '0;
        chk("m_grant", grant, eg);
        chk("m_req_ready", req_ready, er);
        chk("m_tx_valid", tx_valid, m_pv);
        if (m_pv) chk("m_tx_data", tx_data, m_pd);
        chk("m_busy", busy, (m_own >= 0) || m_pv);
        chk("m_timeout", timeout_o, 0);
        if (tx_valid && tx_ready) txd_log.push_back(tx_data);

        if (rst_i) begin
            m_own = -1; m_pv = 1'b0; m_pd = 8'h00; m_rr = 0;
        end else begin
            acc = (m_own >= 0) && req_valid[m_own] && (!m_pv || tx_ready);
            if (acc) begin
                m_pd = req_data[8*m_own +: 8];
                m_pv = 1'b1;
            end else if (m_pv && tx_ready) begin
                m_pv = 1'b0;
            end
            if (m_own < 0) begin
                for (int k = 0; k < N; k++) begin
                    c = (m_rr + k) % N;
                    if (req_valid[c]) begin
                        m_own = c;
                        break;
                    end
                end
            end else if (acc && req_last[m_own]) begin
                m_rr  = (m_own + 1) % N;
                m_own = -1;
            end
        end
    end

    // ---------------- queued requester driver for stream phases ----------------
    bit         drv_en = 1'b0;
    int         vpct   = 100;
    int         rpct   = 100;
    logic [7:0] src_d [N][$];
    bit         src_l [N][$];

    always begin
        bit hs [N];
        @(negedge clk);
        for (int i = 0; i < N; i++) hs[i] = req_valid[i] && req_ready[i];
        @(posedge clk);
        #1;
        if (drv_en) begin
            for (int i = 0; i < N; i++) begin
                if (hs[i] && src_d[i].size() > 0) begin
                    void'(src_d[i].pop_front());
                    void'(src_l[i].pop_front());
                end
                if (src_d[i].size() > 0 && $urandom_range(99) < vpct) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = src_d[i][0];
                    req_last[i]        = src_l[i][0];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'($urandom);
                    req_last[i]        = 1'($urandom);
                end
            end
            tx_ready = ($urandom_range(99) < rpct);
        end
    end

    task automatic wait_drain(input string name, input int budget);
        bit done = 1'b0;
        for (int t = 0; t < budget; t++) begin
            tick();
            if (src_d[0].size() == 0 && src_d[1].size() == 0 && !tx_valid && grant == '0) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, done, 1);
    endtask

    logic [7:0] fair_exp [8] = '{8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hA1, 8'hA2, 8'hB1, 8'hB2};

    initial begin
        int tot;
        int n33;
        int len;

        // Reset held with both requesters asking
        rst_i = 1'b1; req_valid = '1; req_data = '0; req_last = '0; tx_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_grant", grant, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_tx_valid", tx_valid, 0);
            chk("rst_tx_data", tx_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_timeout", timeout_o, 0);
        end
        rst_i = 1'b0;

        // Single message 48 69 0A from requester 0
        req_valid = 2'b01; req_data = {8'h00, 8'h48}; req_last = 2'b00;
        #1;
        chk("p2_arb_grant", grant, 0);
        chk("p2_arb_ready", req_ready, 0);
        tick();
        chk("p2_grant", grant, 2'b01);
        chk("p2_ready", req_ready, 2'b01);
        tick(); req_data[7:0] = 8'h69; #1;
        chk("p2_valid0", tx_valid, 1);
        chk("p2_byte0", tx_data, 8'h48);
        tick(); req_data[7:0] = 8'h0A; req_last = 2'b01; #1;
        chk("p2_byte1", tx_data, 8'h69);
        tick(); req_valid = 2'b00; req_last = 2'b00; #1;
        chk("p2_byte2", tx_data, 8'h0A);
        chk("p2_release", grant, 0);
        tick();
        chk("p2_idle_busy", busy, 0);

        // Fairness: two requesters streaming two-byte messages
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        txd_log.delete();
        for (int m = 0; m < 2; m++) begin
            src_d[0].push_back(8'hA1); src_l[0].push_back(1'b0);
            src_d[0].push_back(8'hA2); src_l[0].push_back(1'b1);
            src_d[1].push_back(8'hB1); src_l[1].push_back(1'b0);
            src_d[1].push_back(8'hB2); src_l[1].push_back(1'b1);
        end
        vpct = 100; rpct = 100; drv_en = 1'b1;
        wait_drain("p3_drain", 200);
        drv_en = 1'b0;
        chk("p3_count", txd_log.size(), 8);
        for (int k = 0; k < 8 && k < txd_log.size(); k++) chk("p3_order", txd_log[k], fair_exp[k]);

        // Backpressure on 0x55, then 0x66 as last byte
        tx_ready = 1'b0; req_valid = 2'b01; req_data = {8'h00, 8'h55}; req_last = 2'b00;
        tick();
        chk("p4_grant", grant, 2'b01);
        tick(); req_data[7:0] = 8'h66; req_last = 2'b01;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("p4_hold_valid", tx_valid, 1);
            chk("p4_hold_data", tx_data, 8'h55);
            chk("p4_hold_ready", req_ready, 0);
            tick();
        end
        tx_ready = 1'b1; #1;
        chk("p4_ready_back", req_ready, 2'b01);
        chk("p4_still_55", tx_data, 8'h55);
        tick(); req_valid = 2'b00; req_last = 2'b00; #1;
        chk("p4_next_byte", tx_data, 8'h66);
        chk("p4_release", grant, 0);
        tick();
        chk("p4_drained", tx_valid, 0);

        // Idle owner keeps the grant while requester 0 waits
        req_valid = 2'b10; req_data = {8'h77, 8'h00}; req_last = 2'b00;
        tick();
        chk("p5_grant", grant, 2'b10);
        tick(); req_valid = 2'b01; req_data = {8'h00, 8'h11}; req_last = 2'b01;
        for (int k = 0; k < 20; k++) begin
            #1;
            chk("p5_hold_grant", grant, 2'b10);
            chk("p5_req0_blocked", req_ready[0], 0);
            tick();
        end
        req_valid = 2'b11; req_data = {8'h78, 8'h11}; req_last = 2'b11; #1;
        chk("p5_owner_ready", req_ready, 2'b10);
        tick(); req_valid = 2'b01; #1;
        chk("p5_release", grant, 0);
        tick();
        chk("p5_req0_next", grant, 2'b01);
        tick(); req_valid = 2'b00; req_last = 2'b00;
        tick(); tick();

        // Reset while 0x33 waits for the transmitter
        tx_ready = 1'b0; req_valid = 2'b01; req_data = {8'h00, 8'h33}; req_last = 2'b00;
        tick();
        chk("p6_grant", grant, 2'b01);
        tick();
        chk("p6_valid33", tx_valid, 1);
        chk("p6_data33", tx_data, 8'h33);
        rst_i = 1'b1;
        tick(); rst_i = 1'b0; tx_ready = 1'b1;
        req_valid = 2'b11; req_data = {8'hB0, 8'hA0}; req_last = 2'b11; #1;
        chk("p6_flushed", tx_valid, 0);
        chk("p6_grant_clr", grant, 0);
        chk("p6_busy_clr", busy, 0);
        tick();
        chk("p6_req0_wins", grant, 2'b01);
        tick(); req_valid = 2'b00; req_last = 2'b00;
        tick(); tick();
        n33 = 0;
        foreach (txd_log[k]) if (txd_log[k] == 8'h33) n33++;
        chk("p6_33_dropped", n33, 0);

        // Randomized message streams with random backpressure
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        txd_log.delete();
        tot = 0;
        for (int r = 0; r < N; r++) begin
            for (int m = 0; m < 8; m++) begin
                len = int'($urandom_range(1, 4));
                for (int b = 0; b < len; b++) begin
                    src_d[r].push_back(8'($urandom));
                    src_l[r].push_back(b == len - 1);
                    tot++;
                end
            end
        end
        vpct = 70; rpct = 60; drv_en = 1'b1;
        wait_drain("p7_drain", 4000);
        drv_en = 1'b0;
        chk("p7_count", txd_log.size(), tot);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter sharing the single UART transmitter between NREQ byte-stream requesters, e.g. core console output and a PC/error trace dumper.
- Grants one requester at a time and holds the grant for a whole message, so messages never interleave on TXD.
- Owns a one-byte output register toward the UART transmitter's valid/ready byte interface.

Parameters:
- NREQ, 2, number of requesters (2..8); requester 0 has priority after reset.
- TIMEOUT_CYCLES, 4096, idle cycles before a locked grant is revoked (used only with ARB_TIMEOUT_EN).

Ports:
- clk  input  1  system clock
- rst_i  input  1  synchronous reset, active-high
- req_valid  input  NREQ  per-requester byte valid
- req_data  input  8*NREQ  per-requester byte; requester i on bits [8i+7:8i]
- req_last  input  NREQ  marks the last byte of a message; qualified by req_valid
- req_ready  output  NREQ  per-requester byte accepted this cycle when valid&ready
- tx_valid  output  1  byte available to the UART transmitter
- tx_data  output  8  byte to transmit
- tx_ready  input  1  UART transmitter accepts tx_data this cycle
- grant  output  NREQ  one-hot current owner; all-zero when unowned
- busy  output  1  grant held or tx_valid high
- timeout_o  output  1  sticky: a grant was revoked by timeout

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr = 0, output register empty.
- States: IDLE, LOCKED.
- IDLE:
  - Any req_valid high: pick the first requester with req_valid high, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - Set grant one-hot next cycle; go to LOCKED. Arbitration costs exactly 1 cycle; no byte is accepted in the arbitration cycle.
- LOCKED, owner g:
  - req_ready[g] = !tx_valid | tx_ready (combinational). All other req_ready bits are 0.
  - Accept (req_valid[g] & req_ready[g]): tx_data <= byte, tx_valid <= 1 on the next edge. Latency is 1 cycle from accept to tx_valid.
  - tx_valid stays high with tx_data stable until tx_ready. Simultaneous tx_ready and new accept gives back-to-back bytes with no bubble.
  - Accept with req_last[g] = 1: grant <= 0, rr_ptr <= (g+1) mod NREQ, state -> IDLE.
  - That last byte still drains from the output register. A new arbitration may occur while it drains.
  - req_valid[g] low while locked: hold the grant. Other requesters wait.
- Wrap: rr_ptr wraps NREQ-1 -> 0.
- A requester dropping req_valid before grant loses nothing; it is simply not selected.
- Reset mid-message: the byte in the output register is discarded, grant cleared, rr_ptr = 0.
- busy = |grant | tx_valid.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - A counter runs in LOCKED while req_valid[g] is low; any accept clears it.
  - Reaching TIMEOUT_CYCLES-1 forces the same release as a last-byte accept: grant <= 0, rr_ptr <= g+1, IDLE. It also sets timeout_o.
  - timeout_o clears only on rst_i.
  - The pending output byte is still transmitted.
- When undefined: no counter logic; timeout_o tied 0; grant is held indefinitely.

Test Plan:
- Reset: rst_i high 3 cycles with req_valid=2'b11 -> grant=0, req_ready=0, tx_valid=0, busy=0, timeout_o=0 throughout.
- Single message: req0 sends 0x48,0x69,0x0A (last on 0x0A), tx_ready always 1 -> grant=2'b01 one cycle after req_valid. tx_data sequence 48,69,0A on consecutive cycles. grant=0 the cycle after 0x0A is accepted.
- Contention and fairness: both requesters continuously send 2-byte messages (req0 A1,A2; req1 B1,B2) -> TXD byte order A1 A2 B1 B2 A1 A2 B1 B2. No interleaving within a message.
- Backpressure: tx_ready low 5 cycles with tx_valid high on 0x55 -> tx_data stays 0x55, req_ready[g]=0. When tx_ready rises, 0x55 is consumed and the next byte appears in the following cycle.
- Idle owner: req1 locked, req_valid[1] low 20 cycles while req0 is valid -> grant stays 2'b10, req_ready[0]=0. With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: grant drops after 8 idle cycles, timeout_o=1, req0 is granted next cycle.
- Reset mid-message: rst_i pulsed while tx_valid=1 with tx_data=0x33 -> tx_valid=0 the next cycle, 0x33 is never accepted by the transmitter, and after reset req0 wins the first arbitration.
